exu_mul_div_dispatch: RTL and testbench
=======================================

Name: exu_mul_div_dispatch

Overview:
Initiator side of the MUL/DIV execution-unit genfifo protocol. Accepts mul/div commands from the pipeline and tags each with a trx_id. Issues them on the request stream, collects responses that may arrive out of order (mul ~2 cycles, div multi-cycle), and retires results to register writeback strictly in issue order through a small reorder buffer. Sits between the issue stage and the MUL/DIV EXU.

Parameters:
DEPTH, 4, reorder-buffer slots = max outstanding ops; power of 2, >=2
TAG_W, 5, width of destination register tag
TRX_W, $clog2(DEPTH), trx_id width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cmd_req_i  in  1  pipeline command valid
cmd_ack_o  out  1  command accepted this cycle when cmd_req_i && cmd_ack_o
cmd_opcode_i  in  3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
cmd_src0_i  in  32  operand A
cmd_src1_i  in  32  operand B
cmd_rd_req_i  in  1  result to be written to register file
cmd_rd_tag_i  in  TAG_W  destination register
stream_req_bus_genfifo_req_o  out  1  request valid to EXU
stream_req_bus_genfifo_wdata_bo  out  req_struct  trx_id, exu_opcode, src0_data, src1_data, rd0_req, rd0_tag
stream_req_bus_genfifo_ack_i  in  1  EXU accepts request
stream_resp_bus_genfifo_req_i  in  1  response valid from EXU
stream_resp_bus_genfifo_rdata_bi  in  resp_struct  trx_id, rd0_req, rd0_tag, rd0_wdata
stream_resp_bus_genfifo_ack_o  out  1  response accept, tied 1
wb_req_o  out  1  in-order retire valid
wb_rd_req_o  out  1  retiring op writes register
wb_rd_tag_o  out  TAG_W  destination register
wb_wdata_o  out  32  result
wb_ack_i  in  1  writeback consumes head
busy_o  out  1  any slot valid or request pending
err_o  out  1  sticky: response hit a non-pending slot

Behaviour:
- Reset (synchronous, active-high): clk_i single clock. All slot valid/done bits, wr_ptr, rd_ptr and count clear to 0. stream_req_bus_genfifo_req_o=0, wb_req_o=0, busy_o=0, err_o=0. Reset mid-operation drops all in-flight state.
- Slot i holds valid, done, rd_req, rd_tag, wdata. trx_id = slot index = wr_ptr at allocation.
- cmd_ack_o = (count < DEPTH) && (!stream_req_bus_genfifo_req_o || stream_req_bus_genfifo_ack_i). A retire in the same cycle does not free a slot for allocation (no bypass). When full, cmd_ack_o=0.
- On command accept (cycle N): slot[wr_ptr] valid=1, done=0; rd_req and rd_tag stored. The request register loads {wr_ptr, opcode, src0, src1, rd_req, rd_tag}. stream_req_bus_genfifo_req_o=1 from N+1. wr_ptr increments modulo DEPTH; count increments.
- Request register: holds its value stably while req_o=1 && !ack_i. It clears req_o after ack unless reloaded the same cycle, so back-to-back issue is possible.
- Responses are always accepted. When resp_req_i is high, slot[trx_id] done=1 and wdata=rd0_wdata. If slot[trx_id] is not valid or is already done: no state change, err_o<=1.
- Retire: wb_req_o = valid[rd_ptr] && done[rd_ptr]. wb_rd_req_o, wb_rd_tag_o and wb_wdata_o come from slot[rd_ptr]. Ops with rd_req=0 still retire through wb_req_o. On wb_req_o && wb_ack_i: slot cleared, rd_ptr increments modulo DEPTH, count decrements.
- Latency: response in cycle M for the head slot -> wb_req_o at M+1 (done is registered, no bypass). Minimum command-to-retire latency = 1 + EXU latency + 1.
- Simultaneous allocate and retire: count unchanged. Simultaneous response and retire to different slots: both take effect.
- busy_o = (count != 0) || stream_req_bus_genfifo_req_o.

Decomposition:
- Shared package (mul_div_exu_pkg): req_struct, resp_struct, and opcode constants 0..7. Used by this block and the EXU.
- Sub-module exu_rob: slot array, pointers and count, with alloc/complete/retire ports. The top level holds the request register and the handshakes.

Test Plan:
- MUL with src0=7, src1=6, rd_tag=5 -> one request trx_id=0, opcode 0. Response wdata=42 -> wb_req_o next cycle with tag 5 and data 42; busy_o falls after wb_ack_i.
- DIVU 100/7 issued, then MUL 3*3. MUL response (trx 1, 9) arrives before DIV response (trx 0, 14) -> retire order 14 then 9; wb_req_o stays low until 14 arrives.
- Issue 5 commands with DEPTH=4 and responses withheld -> cmd_ack_o low on the 5th command. It rises only the cycle after the first retire.
- Hold stream_req_bus_genfifo_ack_i low for 3 cycles -> wdata_bo stable and cmd_ack_o=0 throughout; issue resumes the cycle ack rises.
- Response with trx_id=2 while only slot 0 is valid -> err_o=1 and sticky; slot state unchanged; subsequent traffic unaffected.
- Reset asserted with 3 ops outstanding -> next cycle count=0, wb_req_o=0, busy_o=0; a fresh MUL 2*2 retires 4 from trx_id=0.

Source files
------------

// File: rtl/mul_div_exu_pkg.sv
// Shared MUL/DIV EXU stream definitions: request/response payloads and opcodes.
// Field widths are fixed here so that the dispatcher and the EXU agree on the wire format.
package mul_div_exu_pkg;

  localparam int TRX_ID_W = 4;  // supports up to 16 reorder slots
  localparam int RD_TAG_W = 5;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef struct packed {
    logic [TRX_ID_W-1:0] trx_id;
    logic [2:0]          exu_opcode;
    logic [31:0]         src0_data;
    logic [31:0]         src1_data;
    logic                rd0_req;
    logic [RD_TAG_W-1:0] rd0_tag;
  } req_struct;

  typedef struct packed {
    logic [TRX_ID_W-1:0] trx_id;
    logic                rd0_req;
    logic [RD_TAG_W-1:0] rd0_tag;
    logic [31:0]         rd0_wdata;
  } resp_struct;

endpackage

// File: rtl/exu_rob.sv
// Reorder buffer: slots are allocated in order, completed in any order,
// and retired strictly in allocation order from the head.
module exu_rob #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  localparam int TRX_W = $clog2(DEPTH),
  localparam int CNT_W = TRX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             alloc_rd_req,
  input  logic [TAG_W-1:0] alloc_rd_tag,
  output logic [TRX_W-1:0] alloc_id,
  output logic             space,
  input  logic             complete,
  input  logic [TRX_W-1:0] complete_id,
  input  logic [31:0]      complete_wdata,
  output logic             complete_err,
  input  logic             retire,
  output logic             head_ready,
  output logic             head_rd_req,
  output logic [TAG_W-1:0] head_rd_tag,
  output logic [31:0]      head_wdata,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] valid_q, done_q, rd_req_q;
  logic [TAG_W-1:0] rd_tag_q [DEPTH];
  logic [31:0]      wdata_q  [DEPTH];
  logic [TRX_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             alloc_fire, retire_fire, complete_fire;

  assign space         = (count_q != FULL_CNT);
  assign alloc_fire    = alloc && space;
  assign head_ready    = valid_q[rd_ptr_q] && done_q[rd_ptr_q];
  assign retire_fire   = retire && head_ready;
  assign complete_err  = complete && (!valid_q[complete_id] || done_q[complete_id]);
  assign complete_fire = complete && !complete_err;

  assign alloc_id    = wr_ptr_q;
  assign head_rd_req = rd_req_q[rd_ptr_q];
  assign head_rd_tag = rd_tag_q[rd_ptr_q];
  assign head_wdata  = wdata_q[rd_ptr_q];
  assign count       = count_q;

  // Alloc, completion and retire always address distinct slots when legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      done_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (retire_fire) begin
        valid_q[rd_ptr_q] <= 1'b0;
        done_q[rd_ptr_q]  <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      if (alloc_fire) begin
        valid_q[wr_ptr_q] <= 1'b1;
        done_q[wr_ptr_q]  <= 1'b0;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (complete_fire) done_q[complete_id] <= 1'b1;
      case ({alloc_fire, retire_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rd_req_q[wr_ptr_q] <= alloc_rd_req;
      rd_tag_q[wr_ptr_q] <= alloc_rd_tag;
    end
    if (complete_fire) wdata_q[complete_id] <= complete_wdata;
  end

endmodule

// File: rtl/exu_mul_div_dispatch.sv
// MUL/DIV EXU initiator: tags commands with trx_id, drives the request stream
// and retires out-of-order responses to writeback in issue order.
module exu_mul_div_dispatch
  import mul_div_exu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_req_i,
  output logic             cmd_ack_o,
  input  logic [2:0]       cmd_opcode_i,
  input  logic [31:0]      cmd_src0_i,
  input  logic [31:0]      cmd_src1_i,
  input  logic             cmd_rd_req_i,
  input  logic [TAG_W-1:0] cmd_rd_tag_i,
  output logic             stream_req_bus_genfifo_req_o,
  output req_struct        stream_req_bus_genfifo_wdata_bo,
  input  logic             stream_req_bus_genfifo_ack_i,
  input  logic             stream_resp_bus_genfifo_req_i,
  input  resp_struct       stream_resp_bus_genfifo_rdata_bi,
  output logic             stream_resp_bus_genfifo_ack_o,
  output logic             wb_req_o,
  output logic             wb_rd_req_o,
  output logic [TAG_W-1:0] wb_rd_tag_o,
  output logic [31:0]      wb_wdata_o,
  input  logic             wb_ack_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int TRX_W = $clog2(DEPTH);

  logic             req_vld_q;
  req_struct        req_data_q;
  logic             err_q;
  logic             rob_space, rob_err, accept, resp_id_ok;
  logic [TRX_W-1:0] alloc_id;
  logic [TRX_W:0]   rob_count;
  logic             unused_resp_fields;

  assign cmd_ack_o = rob_space && (!req_vld_q || stream_req_bus_genfifo_ack_i);
  assign accept    = cmd_req_i && cmd_ack_o;

  // A trx_id outside the slot range can never name a pending slot.
  assign resp_id_ok = (32'(stream_resp_bus_genfifo_rdata_bi.trx_id) < DEPTH);
  assign unused_resp_fields = ^{stream_resp_bus_genfifo_rdata_bi.rd0_req,
                                stream_resp_bus_genfifo_rdata_bi.rd0_tag};

  exu_rob #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_rob (
    .clk            (clk_i),
    .rst            (rst_i),
    .alloc          (accept),
    .alloc_rd_req   (cmd_rd_req_i),
    .alloc_rd_tag   (cmd_rd_tag_i),
    .alloc_id       (alloc_id),
    .space          (rob_space),
    .complete       (stream_resp_bus_genfifo_req_i && resp_id_ok),
    .complete_id    (stream_resp_bus_genfifo_rdata_bi.trx_id[TRX_W-1:0]),
    .complete_wdata (stream_resp_bus_genfifo_rdata_bi.rd0_wdata),
    .complete_err   (rob_err),
    .retire         (wb_ack_i),
    .head_ready     (wb_req_o),
    .head_rd_req    (wb_rd_req_o),
    .head_rd_tag    (wb_rd_tag_o),
    .head_wdata     (wb_wdata_o),
    .count          (rob_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept)                            req_vld_q <= 1'b1;
      else if (stream_req_bus_genfifo_ack_i) req_vld_q <= 1'b0;
      if (stream_resp_bus_genfifo_req_i && (!resp_id_ok || rob_err)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_data_q.trx_id     <= TRX_ID_W'(alloc_id);
      req_data_q.exu_opcode <= cmd_opcode_i;
      req_data_q.src0_data  <= cmd_src0_i;
      req_data_q.src1_data  <= cmd_src1_i;
      req_data_q.rd0_req    <= cmd_rd_req_i;
      req_data_q.rd0_tag    <= RD_TAG_W'(cmd_rd_tag_i);
    end
  end

  assign stream_req_bus_genfifo_req_o    = req_vld_q;
  assign stream_req_bus_genfifo_wdata_bo = req_data_q;
  assign stream_resp_bus_genfifo_ack_o   = 1'b1;
  assign busy_o = (rob_count != '0) || req_vld_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_exu_mul_div_dispatch.sv
// Directed bench for exu_mul_div_dispatch: issue, out-of-order completion,
// backpressure, error flagging and reset recovery.
module tb_exu_mul_div_dispatch;
  import mul_div_exu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_req, cmd_ack;
  logic [2:0] cmd_opcode;
  logic [31:0] cmd_src0, cmd_src1;
  logic       cmd_rd_req;
  logic [4:0] cmd_rd_tag;
  logic       req_o, req_ack;
  req_struct  req_bus;
  logic       resp_req, resp_ack;
  resp_struct resp_bus;
  logic       wb_req, wb_rd_req, wb_ack;
  logic [4:0] wb_rd_tag;
  logic [31:0] wb_wdata;
  logic       busy, err;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exu_mul_div_dispatch #(.DEPTH(4), .TAG_W(5)) dut (
    .clk_i                            (clk),
    .rst_i                            (rst),
    .cmd_req_i                        (cmd_req),
    .cmd_ack_o                        (cmd_ack),
    .cmd_opcode_i                     (cmd_opcode),
    .cmd_src0_i                       (cmd_src0),
    .cmd_src1_i                       (cmd_src1),
    .cmd_rd_req_i                     (cmd_rd_req),
    .cmd_rd_tag_i                     (cmd_rd_tag),
    .stream_req_bus_genfifo_req_o     (req_o),
    .stream_req_bus_genfifo_wdata_bo  (req_bus),
    .stream_req_bus_genfifo_ack_i     (req_ack),
    .stream_resp_bus_genfifo_req_i    (resp_req),
    .stream_resp_bus_genfifo_rdata_bi (resp_bus),
    .stream_resp_bus_genfifo_ack_o    (resp_ack),
    .wb_req_o                         (wb_req),
    .wb_rd_req_o                      (wb_rd_req),
    .wb_rd_tag_o                      (wb_rd_tag),
    .wb_wdata_o                       (wb_wdata),
    .wb_ack_i                         (wb_ack),
    .busy_o                           (busy),
    .err_o                            (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
    cmd_req    = 1'b1;
    cmd_opcode = op;
    cmd_src0   = a;
    cmd_src1   = b;
    cmd_rd_req = 1'b1;
    cmd_rd_tag = tag;
  endtask

  task automatic set_resp(input logic [3:0] id, input logic [31:0] data);
    resp_req           = 1'b1;
    resp_bus.trx_id    = id;
    resp_bus.rd0_req   = 1'b1;
    resp_bus.rd0_tag   = 5'd0;
    resp_bus.rd0_wdata = data;
  endtask

  task automatic do_reset();
    cmd_req  = 1'b0;
    resp_req = 1'b0;
    wb_ack   = 1'b0;
    req_ack  = 1'b1;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    cmd_req = 0; cmd_opcode = 0; cmd_src0 = 0; cmd_src1 = 0; cmd_rd_req = 0; cmd_rd_tag = 0;
    req_ack = 1; resp_req = 0; resp_bus = '0; wb_ack = 0; rst = 1;

    // Reset state
    do_reset();
    #1;
    chk("rst_cmd_ack", cmd_ack, 1);
    chk("rst_req_o", req_o, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("resp_ack_tied", resp_ack, 1);

    // Single MUL 7*6 -> 42 to r5
    set_cmd(OP_MUL, 32'd7, 32'd6, 5'd5);
    #1 chk("mul_cmd_ack", cmd_ack, 1);
    tick();
    cmd_req = 0;
    #1;
    chk("mul_req_o", req_o, 1);
    chk("mul_req_trx", req_bus.trx_id, 0);
    chk("mul_req_op", req_bus.exu_opcode, OP_MUL);
    chk("mul_req_src0", req_bus.src0_data, 7);
    chk("mul_req_src1", req_bus.src1_data, 6);
    chk("mul_req_tag", req_bus.rd0_tag, 5);
    chk("mul_busy", busy, 1);
    tick();
    chk("mul_req_clear", req_o, 0);
    set_resp(4'd0, 32'd42);
    #1 chk("mul_wb_not_bypassed", wb_req, 0);
    tick();
    resp_req = 0;
    #1;
    chk("mul_wb_req", wb_req, 1);
    chk("mul_wb_tag", wb_rd_tag, 5);
    chk("mul_wb_data", wb_wdata, 42);
    chk("mul_wb_rd_req", wb_rd_req, 1);
    wb_ack = 1;
    tick();
    wb_ack = 0;
    #1;
    chk("mul_wb_done", wb_req, 0);
    chk("mul_busy_fall", busy, 0);

    // DIVU 100/7 then MUL 3*3; MUL completes first, retire stays in order
    do_reset();
    set_cmd(OP_DIVU, 32'd100, 32'd7, 5'd3);
    tick();
    set_cmd(OP_MUL, 32'd3, 32'd3, 5'd4);
    #1;
    chk("ooo_cmd_ack_b2b", cmd_ack, 1);
    chk("ooo_req0_trx", req_bus.trx_id, 0);
    chk("ooo_req0_op", req_bus.exu_opcode, OP_DIVU);
    tick();
    cmd_req = 0;
    #1;
    chk("ooo_req1_trx", req_bus.trx_id, 1);
    chk("ooo_req1_op", req_bus.exu_opcode, OP_MUL);
    tick();
    set_resp(4'd1, 32'd9);
    tick();
    resp_req = 0;
    #1 chk("ooo_wb_wait0", wb_req, 0);
    tick();
    chk("ooo_wb_wait1", wb_req, 0);
    set_resp(4'd0, 32'd14);
    tick();
    resp_req = 0;
    #1;
    chk("ooo_wb0_req", wb_req, 1);
    chk("ooo_wb0_data", wb_wdata, 14);
    chk("ooo_wb0_tag", wb_rd_tag, 3);
    wb_ack = 1;
    tick();
    chk("ooo_wb1_req", wb_req, 1);
    chk("ooo_wb1_data", wb_wdata, 9);
    chk("ooo_wb1_tag", wb_rd_tag, 4);
    tick();
    wb_ack = 0;
    #1;
    chk("ooo_wb_empty", wb_req, 0);
    chk("ooo_busy", busy, 0);

    // Fill all 4 slots; 5th command stalls until after the first retire
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_cmd(OP_MUL, 32'(i), 32'd1, 5'(i + 1));
      #1 chk("full_accept", cmd_ack, 1);
      tick();
    end
    set_cmd(OP_MUL, 32'd50, 32'd1, 5'd5);
    #1 chk("full_stall0", cmd_ack, 0);
    tick();
    chk("full_stall1", cmd_ack, 0);
    set_resp(4'd0, 32'd100);
    tick();
    resp_req = 0;
    #1;
    chk("full_head_ready", wb_req, 1);
    chk("full_stall2", cmd_ack, 0);
    wb_ack = 1;
    #1 chk("full_no_bypass", cmd_ack, 0);
    tick();
    wb_ack = 0;
    #1 chk("full_ack_after_retire", cmd_ack, 1);
    tick();
    cmd_req = 0;
    #1;
    chk("full_wrap_trx", req_bus.trx_id, 0);
    chk("full_wrap_tag", req_bus.rd0_tag, 5);
    chk("full_wrap_src0", req_bus.src0_data, 50);

    // Request backpressure: payload holds, no new command accepted
    do_reset();
    req_ack = 0;
    set_cmd(OP_MULHU, 32'd11, 32'd12, 5'd7);
    #1 chk("bp_first_ack", cmd_ack, 1);
    tick();
    set_cmd(OP_REM, 32'd13, 32'd14, 5'd8);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_o", req_o, 1);
      chk("bp_hold_src0", req_bus.src0_data, 11);
      chk("bp_hold_op", req_bus.exu_opcode, OP_MULHU);
      chk("bp_cmd_ack", cmd_ack, 0);
      tick();
    end
    req_ack = 1;
    #1 chk("bp_resume_ack", cmd_ack, 1);
    tick();
    cmd_req = 0;
    #1;
    chk("bp_next_src0", req_bus.src0_data, 13);
    chk("bp_next_trx", req_bus.trx_id, 1);
    tick();
    chk("bp_req_clear", req_o, 0);

    // Response to a non-pending slot raises sticky err_o
    do_reset();
    set_cmd(OP_MUL, 32'd5, 32'd11, 5'd2);
    tick();
    cmd_req = 0;
    tick();
    set_resp(4'd2, 32'd77);
    #1 chk("err_before", err, 0);
    tick();
    resp_req = 0;
    #1;
    chk("err_set", err, 1);
    chk("err_no_wb", wb_req, 0);
    tick();
    chk("err_sticky", err, 1);
    set_resp(4'd0, 32'd55);
    tick();
    resp_req = 0;
    #1;
    chk("err_after_wb_req", wb_req, 1);
    chk("err_after_wb_data", wb_wdata, 55);
    chk("err_after_wb_tag", wb_rd_tag, 2);
    wb_ack = 1;
    tick();
    wb_ack = 0;
    #1;
    chk("err_after_busy", busy, 0);
    chk("err_still_set", err, 1);

    // Reset with 3 ops outstanding, then a fresh MUL 2*2
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_cmd(OP_DIV, 32'd90, 32'd3, 5'(i + 10));
      tick();
    end
    cmd_req = 0;
    tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("mid_rst_wb_req", wb_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_o", req_o, 0);
    chk("mid_rst_cmd_ack", cmd_ack, 1);
    set_cmd(OP_MUL, 32'd2, 32'd2, 5'd9);
    tick();
    cmd_req = 0;
    #1 chk("post_rst_trx", req_bus.trx_id, 0);
    tick();
    set_resp(4'd0, 32'd4);
    tick();
    resp_req = 0;
    #1;
    chk("post_rst_wb_req", wb_req, 1);
    chk("post_rst_wb_data", wb_wdata, 4);
    chk("post_rst_wb_tag", wb_rd_tag, 9);
    wb_ack = 1;
    tick();
    wb_ack = 0;
    #1 chk("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
